ram_test_seq: RTL

Parametrised self-test sequencer for the DDR RAM tester. Over the tester's single-beat config write port it programs the address range, then issues one write pass and one read/verify pass for each enabled data pattern, optionally looping forever. It monitors tester busy/error, enforces a per-pass timeout, and drives active-low RGB status LEDs. It sits between the board-level top and `fpga_top`, replacing the hard-coded test-index sequence.

---
 rtl/ram_test_pkg.sv | 64 ++++++
 rtl/ram_test_cfg_wr.sv | 55 +++++
 rtl/ram_test_seq.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_test_pkg.sv
// Shared definitions for the DDR RAM tester self-test sequencer.
//   - Register offsets of the tester's config port.
//   - CFG register field positions.
//   - Sequencer state encoding.
//   - Helpers for pattern selection and CFG word construction.
package ram_test_pkg;

  // Register offsets
  localparam logic [7:0] REG_CFG     = 8'h00;
  localparam logic [7:0] REG_BASE    = 8'h04;
  localparam logic [7:0] REG_END     = 8'h08;
  localparam logic [7:0] REG_STS     = 8'h0C;
  localparam logic [7:0] REG_CURRENT = 8'h10;
  localparam logic [7:0] REG_WRITE   = 8'h14;
  localparam logic [7:0] REG_TIME    = 8'h18;
  localparam logic [7:0] REG_ERRORS  = 8'h1C;
  localparam logic [7:0] REG_LAST    = 8'h20;

  // CFG field positions
  localparam int CFG_BURST_LEN_MSB = 31;
  localparam int CFG_BURST_LEN_LSB = 28;
  localparam int CFG_READ          = 8;
  localparam int CFG_RND_DELAY     = 7;
  localparam int CFG_USER          = 3;
  localparam int CFG_INCR          = 2;
  localparam int CFG_ONES          = 1;
  localparam int CFG_ZERO          = 0;

  // Sequencer states
  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_WR_BASE  = 4'd1;
  localparam state_t ST_WR_END   = 4'd2;
  localparam state_t ST_SEL      = 4'd3;
  localparam state_t ST_WR_USER  = 4'd4;
  localparam state_t ST_WR_CFG_W = 4'd5;
  localparam state_t ST_WAIT_W   = 4'd6;
  localparam state_t ST_WR_CFG_R = 4'd7;
  localparam state_t ST_WAIT_R   = 4'd8;
  localparam state_t ST_DONE     = 4'd9;
  localparam state_t ST_FAIL     = 4'd10;

  // Lowest enabled pattern index >= from; 3'd4 means none left.
  function automatic logic [2:0] next_pattern(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] r;
    r = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) r = 3'(i);
    end
    return r;
  endfunction

  // CFG word: burst length, read/write select and one-hot pattern bit.
  function automatic logic [31:0] cfg_word(input logic [3:0] burst_m1, input logic [1:0] pat,
                                           input logic rd);
    logic [31:0] w;
    w = '0;
    w[CFG_BURST_LEN_MSB:CFG_BURST_LEN_LSB] = burst_m1;
    w[CFG_READ] = rd;
    w[3:0] = 4'b0001 << pat;
    return w;
  endfunction

endpackage

// File: rtl/ram_test_cfg_wr.sv
// Single-entry request-hold register for the tester config write port.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   load_i            : capture addr_i/data_i and raise req_o
//   flush_i           : drop a pending request without it being accepted
//   accept_i          : port handshake; clears req_o when it is pending
//   req_o/addr_o/data_o : registered request, stable while pending
module ram_test_cfg_wr (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic        accept_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] data_i,
  output logic        req_o,
  output logic [7:0]  addr_o,
  output logic [31:0] data_o
);

  logic        req_q, req_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;

  always_comb begin
    req_d  = req_q;
    addr_d = addr_q;
    data_d = data_q;
    if (flush_i) begin
      req_d = 1'b0;
    end else if (load_i) begin
      req_d  = 1'b1;
      addr_d = addr_i;
      data_d = data_i;
    end else if (accept_i && req_q) begin
      req_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      req_q  <= req_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign req_o  = req_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule

// File: rtl/ram_test_seq.sv
// Self-test sequencer for the DDR RAM tester.
// Programs BASE/END, then runs a write pass and a read/verify pass for each
// enabled pattern (optionally looping), watching tester busy/error and an
// optional per-pass busy timeout. Drives active-low RGB status LEDs.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   start_i                : rising edge restarts from IDLE/DONE/FAIL
//   cfg_req_o/addr/data    : config write request (awvalid+wvalid), offset, data
//   cfg_accept_i           : config write accepted
//   status_busy_i/err_i    : tester busy, tester sticky compare error
//   done_o/fail_o/timeout_o: completion and failure flags
//   pattern_o/read_phase_o : current pattern index, read pass in progress
//   loop_count_o           : completed pattern lists (saturating)
//   led_r_o/led_g_o/led_b_o: active-low status LEDs, all bits equal
module ram_test_seq
  import ram_test_pkg::*;
#(
  parameter logic [31:0] DDR_SIZE       = 32'h2000_0000,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned BURST_WORDS    = 4,
  parameter logic [3:0]  PATTERN_MASK   = 4'b0110,
  parameter logic [31:0] USER_PATTERN   = 32'hA5A5_5A5A,
  parameter int unsigned START_DELAY    = 100,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter bit          LOOP           = 1'b0,
  parameter int unsigned LED_W          = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  output logic             cfg_req_o,
  output logic [7:0]       cfg_addr_o,
  output logic [31:0]      cfg_data_o,
  input  logic             cfg_accept_i,
  input  logic             status_busy_i,
  input  logic             status_err_i,
  output logic             done_o,
  output logic             fail_o,
  output logic             timeout_o,
  output logic [1:0]       pattern_o,
  output logic             read_phase_o,
  output logic [15:0]      loop_count_o,
  output logic [LED_W-1:0] led_r_o,
  output logic [LED_W-1:0] led_g_o,
  output logic [LED_W-1:0] led_b_o
);

  localparam logic [3:0] BURST_M1 = 4'(BURST_WORDS - 1);
  localparam logic [31:0] PHASE_A_LAST = 32'd15;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;      // IDLE start delay / WAIT phase-A cycles
  logic [31:0] tmo_q, tmo_d;      // busy cycles within the current WAIT
  logic        phase_b_q, phase_b_d;
  logic [2:0]  cur_q, cur_d;      // search start for the next pattern
  logic [1:0]  pattern_q, pattern_d;
  logic        armed_q, armed_d;  // first cfg write accepted; errors count from here
  logic        start_q, start_d;
  logic        done_q, done_d, fail_q, fail_d, timeout_q, timeout_d;
  logic        read_phase_q, read_phase_d;
  logic [15:0] loop_count_q, loop_count_d;
  logic        green_tgl_q, green_tgl_d;
  logic        led_r_q, led_r_d, led_g_q, led_g_d, led_b_q, led_b_d;

  logic        cfg_req;
  logic        load, flush;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
  logic        accept_fire, start_rise, err_fire, tmo_hit, wait_done, in_wait;
  logic [2:0]  sel, first;

  ram_test_cfg_wr u_cfg_wr (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (load),
    .flush_i  (flush),
    .accept_i (cfg_accept_i),
    .addr_i   (ld_addr),
    .data_i   (ld_data),
    .req_o    (cfg_req),
    .addr_o   (cfg_addr_o),
    .data_o   (cfg_data_o)
  );

  assign accept_fire = cfg_req && cfg_accept_i;
  assign start_rise  = start_i && !start_q;
  assign in_wait     = (state_q == ST_WAIT_W) || (state_q == ST_WAIT_R);
  // An accept in the same cycle as the error still counts as the first write.
  assign err_fire    = status_err_i && (armed_q || accept_fire) &&
                       (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_FAIL);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    phase_b_d    = phase_b_q;
    cur_d        = cur_q;
    pattern_d    = pattern_q;
    armed_d      = armed_q || accept_fire;
    start_d      = start_i;
    timeout_d    = timeout_q;
    loop_count_d = loop_count_q;
    green_tgl_d  = green_tgl_q;
    load         = 1'b0;
    flush        = 1'b0;
    ld_addr      = REG_CFG;
    ld_data      = '0;
    tmo_hit      = 1'b0;
    wait_done    = 1'b0;
    sel          = next_pattern(PATTERN_MASK, cur_q);
    first        = next_pattern(PATTERN_MASK, 3'd0);

    // Busy cycles count towards the timeout; the first busy cycle already
    // belongs to phase B, so the timeout covers the whole observed busy run.
    if (in_wait) begin
      if (status_busy_i) begin
        tmo_d     = (tmo_q == '1) ? tmo_q : tmo_q + 32'd1;
        tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_q >= TIMEOUT_CYCLES);
        phase_b_d = 1'b1;
      end else if (phase_b_q) begin
        wait_done = 1'b1;
      end else if (cnt_q == PHASE_A_LAST) begin
        phase_b_d = 1'b1;  // pass too short to see busy
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          cnt_d = '0;
        end else if (cnt_q >= START_DELAY) begin
          state_d = ST_WR_BASE;
          load    = 1'b1;
          ld_addr = REG_BASE;
          ld_data = BASE_ADDR;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_WR_BASE: begin
        if (!cfg_req) begin
          load = 1'b1; ld_addr = REG_BASE; ld_data = BASE_ADDR;
        end else if (accept_fire) begin
          state_d = ST_WR_END;
        end
      end
      ST_WR_END: begin
        if (!cfg_req) begin
          load = 1'b1; ld_addr = REG_END; ld_data = DDR_SIZE;
        end else if (accept_fire) begin
          state_d = ST_SEL;
        end
      end
      ST_SEL: begin
        if (!sel[2]) begin
          pattern_d = sel[1:0];
          state_d   = (sel == 3'd3) ? ST_WR_USER : ST_WR_CFG_W;
        end else if (LOOP && !first[2]) begin
          loop_count_d = (loop_count_q == 16'hFFFF) ? loop_count_q : loop_count_q + 16'd1;
          green_tgl_d  = !green_tgl_q;
          pattern_d    = first[1:0];
          state_d      = (first == 3'd3) ? ST_WR_USER : ST_WR_CFG_W;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_WR_USER: begin
        if (!cfg_req) begin
          load = 1'b1; ld_addr = REG_WRITE; ld_data = USER_PATTERN;
        end else if (accept_fire) begin
          state_d = ST_WR_CFG_W;
        end
      end
      ST_WR_CFG_W, ST_WR_CFG_R: begin
        if (!cfg_req) begin
          load    = 1'b1;
          ld_addr = REG_CFG;
          ld_data = cfg_word(BURST_M1, pattern_q, state_q == ST_WR_CFG_R);
        end else if (accept_fire) begin
          state_d   = (state_q == ST_WR_CFG_R) ? ST_WAIT_R : ST_WAIT_W;
          cnt_d     = '0;
          tmo_d     = '0;
          phase_b_d = 1'b0;
        end
      end
      ST_WAIT_W: begin
        if (wait_done) state_d = ST_WR_CFG_R;
      end
      ST_WAIT_R: begin
        if (wait_done) begin
          state_d = ST_SEL;
          cur_d   = {1'b0, pattern_q} + 3'd1;
        end
      end
      ST_DONE, ST_FAIL: begin
        if (start_rise) begin
          state_d      = ST_IDLE;
          cnt_d        = '0;
          cur_d        = '0;
          pattern_d    = '0;
          armed_d      = 1'b0;
          timeout_d    = 1'b0;
          loop_count_d = '0;
          green_tgl_d  = 1'b0;
          phase_b_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Failure wins over any load decided above; a stalled request is dropped.
    if (err_fire || tmo_hit) begin
      state_d = ST_FAIL;
      load    = 1'b0;
      flush   = 1'b1;
      if (!err_fire) timeout_d = 1'b1;
    end

    done_d       = (state_d == ST_DONE);
    fail_d       = (state_d == ST_FAIL);
    read_phase_d = (state_d == ST_WAIT_R);
    led_r_d      = !(state_d == ST_FAIL);
    led_g_d      = !((state_d == ST_DONE) || (LOOP && green_tgl_d && (state_d != ST_FAIL)));
    led_b_d      = !((state_d != ST_DONE) && (state_d != ST_FAIL));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      tmo_q        <= '0;
      phase_b_q    <= 1'b0;
      cur_q        <= '0;
      pattern_q    <= '0;
      armed_q      <= 1'b0;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
      read_phase_q <= 1'b0;
      loop_count_q <= '0;
      green_tgl_q  <= 1'b0;
      led_r_q      <= 1'b1;
      led_g_q      <= 1'b1;
      led_b_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      phase_b_q    <= phase_b_d;
      cur_q        <= cur_d;
      pattern_q    <= pattern_d;
      armed_q      <= armed_d;
      start_q      <= start_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      timeout_q    <= timeout_d;
      read_phase_q <= read_phase_d;
      loop_count_q <= loop_count_d;
      green_tgl_q  <= green_tgl_d;
      led_r_q      <= led_r_d;
      led_g_q      <= led_g_d;
      led_b_q      <= led_b_d;
    end
  end

  assign cfg_req_o    = cfg_req;
  assign done_o       = done_q;
  assign fail_o       = fail_q;
  assign timeout_o    = timeout_q;
  assign pattern_o    = pattern_q;
  assign read_phase_o = read_phase_q;
  assign loop_count_o = loop_count_q;

  for (genvar gi = 0; gi < LED_W; gi++) begin : g_led
    assign led_r_o[gi] = led_r_q;
    assign led_g_o[gi] = led_g_q;
    assign led_b_o[gi] = led_b_q;
  end

endmodule
